// File: rtl/linemult_pkg.sv
// Shared defaults, multiplication-range limits and the timing-window struct for the line multiplier.
package linemult_pkg;

    localparam int unsigned H_CNT_W_DEF  = 12;
    localparam int unsigned V_CNT_W_DEF  = 11;
    localparam int unsigned COLOR_W_DEF  = 8;
    localparam int unsigned MAX_MULT_DEF = 5;
    localparam int unsigned WARN_W_DEF   = 24;

    localparam int unsigned MULT_MIN   = 1;
    localparam int unsigned MULT_LIMIT = 7;

    // Window arithmetic runs at this width so sums of counter-width fields cannot overflow.
    localparam int unsigned TCFG_W = 16;

    typedef struct packed {
        logic [TCFG_W-1:0] sync_len;
        logic [TCFG_W-1:0] act_start;
        logic [TCFG_W-1:0] act_stop;
        logic [TCFG_W-1:0] mask;
    } tcfg_t;

    function automatic tcfg_t mk_tcfg(input logic [TCFG_W-1:0] sync_len,
                                      input logic [TCFG_W-1:0] backporch,
                                      input logic [TCFG_W-1:0] active,
                                      input logic [TCFG_W-1:0] mask);
        tcfg_t t;
        t.sync_len  = sync_len;
        t.act_start = sync_len + backporch;
        t.act_stop  = sync_len + backporch + active;
        t.mask      = mask;
        return t;
    endfunction

    function automatic logic in_active(input tcfg_t t, input logic [TCFG_W-1:0] pos);
        return (pos >= t.act_start) && (pos < t.act_stop);
    endfunction

    // Written as pos+mask < stop so an oversized mask yields an empty window, never a wrap.
    function automatic logic in_unmasked(input tcfg_t t, input logic [TCFG_W-1:0] pos);
        return (pos >= t.act_start + t.mask) && (pos + t.mask < t.act_stop);
    endfunction

    function automatic logic [2:0] clamp_mult(input logic [2:0] req, input int unsigned max_mult);
        int unsigned lim;
        lim = (max_mult > MULT_LIMIT) ? MULT_LIMIT : max_mult;
        if (req == 3'd0 || 32'(req) > lim)
            return 3'(MULT_MIN);
        return req;
    endfunction

endpackage

// File: rtl/linemult_pixproc.sv
// Per-component pixel stages 2 (mask blanking) and 3 (scanline darkening).
// Scanline darkening exists only when LINEMULT_SCANLINES_EN is defined; otherwise stage 3 is a plain delay.
module linemult_pixproc
    import linemult_pkg::*;
#(
    parameter int unsigned COLOR_W = COLOR_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [COLOR_W-1:0] pix_i,
    input  logic               vis_i,
    input  logic               sl_hit_i,
    input  logic [COLOR_W-1:0] sl_str_i,
    output logic [COLOR_W-1:0] pix_o
);

    logic [COLOR_W-1:0] pix2_q;
    logic [COLOR_W-1:0] pix3_q;

`ifdef LINEMULT_SCANLINES_EN
    logic sl2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix2_q <= '0;
            sl2_q  <= 1'b0;
            pix3_q <= '0;
        end else begin
            pix2_q <= vis_i ? pix_i : '0;
            sl2_q  <= sl_hit_i;
            if (sl2_q)
                pix3_q <= (pix2_q > sl_str_i) ? (pix2_q - sl_str_i) : '0;
            else
                pix3_q <= pix2_q;
        end
    end
`else
    logic unused_sl;
    assign unused_sl = ^{sl_hit_i, sl_str_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix2_q <= '0;
            pix3_q <= '0;
        end else begin
            pix2_q <= vis_i ? pix_i : '0;
            pix3_q <= pix2_q;
        end
    end
`endif

    assign pix_o = pix3_q;

endmodule

// File: rtl/linemult_timing_gen.sv
// Line-multiplying output timing generator: sub-line counters, sync/DE and 3-stage pixel pipeline.
// LINEMULT_SCANLINES_EN enables scanline darkening in linemult_pixproc; latency is 3 either way.
module linemult_timing_gen
    import linemult_pkg::*;
#(
    parameter int unsigned H_CNT_W  = H_CNT_W_DEF,
    parameter int unsigned V_CNT_W  = V_CNT_W_DEF,
    parameter int unsigned COLOR_W  = COLOR_W_DEF,
    parameter int unsigned MAX_MULT = MAX_MULT_DEF,
    parameter int unsigned WARN_W   = WARN_W_DEF
) (
    input  logic               PCLK_in,
    input  logic               reset_n,
    input  logic               hs_lead,
    input  logic               vs_lead,
    input  logic [H_CNT_W-1:0] cfg_hmax,
    input  logic [2:0]         cfg_mult,
    input  logic [H_CNT_W-1:0] cfg_h_synclen,
    input  logic [H_CNT_W-1:0] cfg_h_backporch,
    input  logic [H_CNT_W-1:0] cfg_h_active,
    input  logic [H_CNT_W-1:0] cfg_h_mask,
    input  logic [V_CNT_W-1:0] cfg_v_synclen,
    input  logic [V_CNT_W-1:0] cfg_v_backporch,
    input  logic [V_CNT_W-1:0] cfg_v_active,
    input  logic [V_CNT_W-1:0] cfg_v_mask,
    input  logic               cfg_sl_en,
    input  logic [2:0]         cfg_sl_id,
    input  logic [COLOR_W-1:0] cfg_sl_str,
    input  logic [COLOR_W-1:0] R_lbuf,
    input  logic [COLOR_W-1:0] G_lbuf,
    input  logic [COLOR_W-1:0] B_lbuf,
    output logic [H_CNT_W:0]   lbuf_rdaddr,
    output logic [COLOR_W-1:0] R_out,
    output logic [COLOR_W-1:0] G_out,
    output logic [COLOR_W-1:0] B_out,
    output logic               HSYNC_out,
    output logic               VSYNC_out,
    output logic               DE_out,
    output logic [V_CNT_W-1:0] lines_out,
    output logic               h_unstable
);

    localparam logic [2:0] SYNC_IDLE = 3'b110;  // {hsync, vsync, de}

    logic [H_CNT_W-1:0] hcnt_q, hcnt_d;
    logic [2:0]         sub_idx_q, sub_idx_d;
    logic [V_CNT_W-1:0] vcnt_q, vcnt_d;
    logic               wr_half_q, wr_half_d;
    logic [2:0]         mult_act_q, mult_act_d;
    logic [V_CNT_W-1:0] lines_q, lines_d;
    logic [WARN_W-1:0]  warn_q, warn_d;
    logic [2:0]         last_sub;

    assign last_sub = mult_act_q - 3'd1;

    always_comb begin
        hcnt_d     = hcnt_q + H_CNT_W'(1);
        sub_idx_d  = sub_idx_q;
        vcnt_d     = vcnt_q;
        wr_half_d  = wr_half_q;
        mult_act_d = mult_act_q;
        lines_d    = lines_q;
        warn_d     = warn_q;

        if (hs_lead) begin
            hcnt_d    = '0;
            sub_idx_d = '0;
            vcnt_d    = vcnt_q + V_CNT_W'(1);
            wr_half_d = ~wr_half_q;
        end else if (hcnt_q == cfg_hmax) begin
            hcnt_d    = '0;
            sub_idx_d = (sub_idx_q < last_sub) ? sub_idx_q + 3'd1 : last_sub;
        end

        if (vs_lead) begin
            vcnt_d     = '0;
            lines_d    = vcnt_q;
            mult_act_d = clamp_mult(cfg_mult, MAX_MULT);
        end

        // A line start anywhere but the end of the last sub-line restarts the hold-off.
        if (hs_lead && (sub_idx_q != last_sub || hcnt_q != cfg_hmax))
            warn_d = WARN_W'(1);
        else if (warn_q != '0)
            warn_d = warn_q + WARN_W'(1);
    end

    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q     <= '0;
            sub_idx_q  <= '0;
            vcnt_q     <= '0;
            wr_half_q  <= 1'b0;
            mult_act_q <= 3'(MULT_MIN);
            lines_q    <= '0;
            warn_q     <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            sub_idx_q  <= sub_idx_d;
            vcnt_q     <= vcnt_d;
            wr_half_q  <= wr_half_d;
            mult_act_q <= mult_act_d;
            lines_q    <= lines_d;
            warn_q     <= warn_d;
        end
    end

    assign lbuf_rdaddr = {~wr_half_q, hcnt_q};
    assign lines_out   = lines_q;
    assign h_unstable  = (warn_q != '0);

    tcfg_t             h_tc, v_tc;
    logic [TCFG_W-1:0] hpos, vpos;
    logic [2:0]        sync1_d, sync1_q, sync2_q, sync3_q;
    logic              vis1_d, vis1_q, sl1_d, sl1_q;

    assign h_tc = mk_tcfg(TCFG_W'(cfg_h_synclen), TCFG_W'(cfg_h_backporch),
                          TCFG_W'(cfg_h_active), TCFG_W'(cfg_h_mask));
    assign v_tc = mk_tcfg(TCFG_W'(cfg_v_synclen), TCFG_W'(cfg_v_backporch),
                          TCFG_W'(cfg_v_active), TCFG_W'(cfg_v_mask));
    assign hpos = TCFG_W'(hcnt_q);
    assign vpos = TCFG_W'(vcnt_q);

    assign sync1_d = {~(hpos < h_tc.sync_len), ~(vpos < v_tc.sync_len),
                      in_active(h_tc, hpos) && in_active(v_tc, vpos)};
    assign vis1_d  = in_unmasked(h_tc, hpos) && in_unmasked(v_tc, vpos);
    assign sl1_d   = cfg_sl_en && (sub_idx_q == cfg_sl_id);

    // Stage-1 flags line up with the line-buffer data, which lags the address by one cycle.
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= SYNC_IDLE;
            sync2_q <= SYNC_IDLE;
            sync3_q <= SYNC_IDLE;
            vis1_q  <= 1'b0;
            sl1_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            vis1_q  <= vis1_d;
            sl1_q   <= sl1_d;
        end
    end

    assign HSYNC_out = sync3_q[2];
    assign VSYNC_out = sync3_q[1];
    assign DE_out    = sync3_q[0];

    linemult_pixproc #(.COLOR_W(COLOR_W)) u_pix_r (
        .clk_i    (PCLK_in),
        .rst_ni   (reset_n),
        .pix_i    (R_lbuf),
        .vis_i    (vis1_q),
        .sl_hit_i (sl1_q),
        .sl_str_i (cfg_sl_str),
        .pix_o    (R_out)
    );

    linemult_pixproc #(.COLOR_W(COLOR_W)) u_pix_g (
        .clk_i    (PCLK_in),
        .rst_ni   (reset_n),
        .pix_i    (G_lbuf),
        .vis_i    (vis1_q),
        .sl_hit_i (sl1_q),
        .sl_str_i (cfg_sl_str),
        .pix_o    (G_out)
    );

    linemult_pixproc #(.COLOR_W(COLOR_W)) u_pix_b (
        .clk_i    (PCLK_in),
        .rst_ni   (reset_n),
        .pix_i    (B_lbuf),
        .vis_i    (vis1_q),
        .sl_hit_i (sl1_q),
        .sl_str_i (cfg_sl_str),
        .pix_o    (B_out)
    );

endmodule

// File: tb/tb_linemult_timing_gen.sv
// Directed bench for linemult_timing_gen; expectations follow LINEMULT_SCANLINES_EN when it is defined.
module tb_linemult_timing_gen;

    localparam int unsigned H_CNT_W  = 12;
    localparam int unsigned V_CNT_W  = 11;
    localparam int unsigned COLOR_W  = 8;
    localparam int unsigned MAX_MULT = 5;
    localparam int unsigned WARN_W   = 6;

`ifdef LINEMULT_SCANLINES_EN
    localparam bit SL_BUILD = 1'b1;
`else
    localparam bit SL_BUILD = 1'b0;
`endif

    logic               PCLK_in = 1'b0;
    logic               reset_n;
    logic               hs_lead, vs_lead;
    logic [H_CNT_W-1:0] cfg_hmax;
    logic [2:0]         cfg_mult;
    logic [H_CNT_W-1:0] cfg_h_synclen, cfg_h_backporch, cfg_h_active, cfg_h_mask;
    logic [V_CNT_W-1:0] cfg_v_synclen, cfg_v_backporch, cfg_v_active, cfg_v_mask;
    logic               cfg_sl_en;
    logic [2:0]         cfg_sl_id;
    logic [COLOR_W-1:0] cfg_sl_str;
    logic [COLOR_W-1:0] R_lbuf, G_lbuf, B_lbuf;
    logic [H_CNT_W:0]   lbuf_rdaddr;
    logic [COLOR_W-1:0] R_out, G_out, B_out;
    logic               HSYNC_out, VSYNC_out, DE_out;
    logic [V_CNT_W-1:0] lines_out;
    logic               h_unstable;

    int n_tests = 0;
    int n_fail  = 0;
    int j       = 0;

    linemult_timing_gen #(
        .H_CNT_W  (H_CNT_W),
        .V_CNT_W  (V_CNT_W),
        .COLOR_W  (COLOR_W),
        .MAX_MULT (MAX_MULT),
        .WARN_W   (WARN_W)
    ) dut (
        .PCLK_in         (PCLK_in),
        .reset_n         (reset_n),
        .hs_lead         (hs_lead),
        .vs_lead         (vs_lead),
        .cfg_hmax        (cfg_hmax),
        .cfg_mult        (cfg_mult),
        .cfg_h_synclen   (cfg_h_synclen),
        .cfg_h_backporch (cfg_h_backporch),
        .cfg_h_active    (cfg_h_active),
        .cfg_h_mask      (cfg_h_mask),
        .cfg_v_synclen   (cfg_v_synclen),
        .cfg_v_backporch (cfg_v_backporch),
        .cfg_v_active    (cfg_v_active),
        .cfg_v_mask      (cfg_v_mask),
        .cfg_sl_en       (cfg_sl_en),
        .cfg_sl_id       (cfg_sl_id),
        .cfg_sl_str      (cfg_sl_str),
        .R_lbuf          (R_lbuf),
        .G_lbuf          (G_lbuf),
        .B_lbuf          (B_lbuf),
        .lbuf_rdaddr     (lbuf_rdaddr),
        .R_out           (R_out),
        .G_out           (G_out),
        .B_out           (B_out),
        .HSYNC_out       (HSYNC_out),
        .VSYNC_out       (VSYNC_out),
        .DE_out          (DE_out),
        .lines_out       (lines_out),
        .h_unstable      (h_unstable)
    );

    always #5 PCLK_in = ~PCLK_in;

    // Line buffer model: one-cycle read latency, red data equals the low address byte.
    always @(posedge PCLK_in) R_lbuf <= lbuf_rdaddr[7:0];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK_in);
            #1;
            j++;
        end
    endtask

    task automatic run_to(input int target);
        while (j < target) tick(1);
    endtask

    task automatic hs_pulse(input logic vs);
        hs_lead = 1'b1;
        vs_lead = vs;
        tick(1);
        hs_lead = 1'b0;
        vs_lead = 1'b0;
        j = 0;
    endtask

    function automatic logic [2:0] sub_now();
        return dut.sub_idx_q;
    endfunction

    function automatic logic [H_CNT_W-1:0] hcnt_now();
        return lbuf_rdaddr[H_CNT_W-1:0];
    endfunction

    initial begin
        reset_n         = 1'b0;
        hs_lead         = 1'b0;
        vs_lead         = 1'b0;
        cfg_hmax        = 12'd99;
        cfg_mult        = 3'd5;
        cfg_h_synclen   = 12'd10;
        cfg_h_backporch = 12'd10;
        cfg_h_active    = 12'd60;
        cfg_h_mask      = 12'd5;
        cfg_v_synclen   = 11'd2;
        cfg_v_backporch = 11'd2;
        cfg_v_active    = 11'd10;
        cfg_v_mask      = 11'd1;
        cfg_sl_en       = 1'b1;
        cfg_sl_id       = 3'd1;
        cfg_sl_str      = 8'h40;
        G_lbuf          = 8'h30;
        B_lbuf          = 8'hFF;

        tick(3);
        check_eq("rst_hsync", HSYNC_out, 1);
        check_eq("rst_vsync", VSYNC_out, 1);
        check_eq("rst_de", DE_out, 0);
        check_eq("rst_rgb", {R_out, G_out, B_out}, 0);
        check_eq("rst_lines", lines_out, 0);
        check_eq("rst_unstable", h_unstable, 0);
        check_eq("rst_rdaddr", lbuf_rdaddr, 13'h1000);

        // Free-run from zero after reset with mult_act = 1
        reset_n = 1'b1;
        tick(7);
        check_eq("free_h7", lbuf_rdaddr, 13'h1007);
        tick(92);
        check_eq("free_h99", lbuf_rdaddr, 13'h1063);
        tick(1);
        check_eq("free_wrap", lbuf_rdaddr, 13'h1000);
        check_eq("free_sub", sub_now(), 0);
        tick(99);

        // Frame start, mult 5, line with vcnt 0
        hs_pulse(1'b1);
        check_eq("fs_rdaddr", lbuf_rdaddr, 13'h0000);
        check_eq("fs_lines0", lines_out, 0);
        check_eq("fs_unstable", h_unstable, 0);
        run_to(10);  check_eq("l0_vsync", VSYNC_out, 0);
        run_to(12);  check_eq("l0_hsync_lo", HSYNC_out, 0);
        run_to(13);  check_eq("l0_hsync_hi", HSYNC_out, 1);
        run_to(150); check_eq("l0_sub1", sub_now(), 1);
                     check_eq("l0_rdaddr150", lbuf_rdaddr, 13'h0032);
        run_to(499); check_eq("l0_sub4", sub_now(), 4);
                     check_eq("l0_h99", hcnt_now(), 99);

        for (int l = 1; l <= 3; l++) begin
            hs_pulse(1'b0);
            run_to(499);
        end
        check_eq("l3_stable", h_unstable, 0);

        // vcnt 4: inside DE window, outside the masked window
        hs_pulse(1'b0);
        run_to(22);  check_eq("l4_de_pre", DE_out, 0);
        run_to(23);  check_eq("l4_de_start", DE_out, 1);
        run_to(53);  check_eq("l4_de_mid", DE_out, 1);
                     check_eq("l4_vmask_r", R_out, 0);
        run_to(82);  check_eq("l4_de_last", DE_out, 1);
        run_to(83);  check_eq("l4_de_end", DE_out, 0);
        run_to(123); check_eq("l4_de_sub1", DE_out, 1);
        run_to(499);

        // vcnt 5: visible pixels, scanline on sub-line 1
        hs_pulse(1'b0);
        run_to(10);  check_eq("l5_vsync", VSYNC_out, 1);
        run_to(27);  check_eq("l5_hmask_lo", R_out, 8'h00);
        run_to(28);  check_eq("l5_r25", R_out, 8'h19);
        run_to(53);  check_eq("l5_r50", R_out, 8'h32);
                     check_eq("l5_g_sub0", G_out, 8'h30);
        run_to(77);  check_eq("l5_r74", R_out, 8'h4A);
        run_to(78);  check_eq("l5_hmask_hi", R_out, 8'h00);
        run_to(153); check_eq("l5_g_sub1", G_out, SL_BUILD ? 8'h00 : 8'h30);
                     check_eq("l5_b_sub1", B_out, SL_BUILD ? 8'hBF : 8'hFF);
                     check_eq("l5_r_sub1", R_out, SL_BUILD ? 8'h00 : 8'h32);
        run_to(253); check_eq("l5_g_sub2", G_out, 8'h30);
        run_to(499);

        // Simultaneous hs/vs latches the previous line count; mult change waits for vs
        cfg_mult = 3'd2;
        hs_pulse(1'b1);
        check_eq("fs2_lines5", lines_out, 5);
        check_eq("fs2_stable", h_unstable, 0);
        run_to(10);  check_eq("fs2_vsync_v0", VSYNC_out, 0);
        run_to(100); cfg_mult = 3'd3;
        run_to(150); check_eq("m2_sub150", sub_now(), 1);
        run_to(199); check_eq("m2_sub199", sub_now(), 1);
        hs_pulse(1'b0);
        check_eq("m2_stable", h_unstable, 0);
        run_to(199); check_eq("m2_still2", sub_now(), 1);
        hs_pulse(1'b1);
        check_eq("fs3_lines1", lines_out, 1);
        run_to(250); check_eq("m3_sub2", sub_now(), 2);
        run_to(299);

        // mult 0 and mult above MAX_MULT both fall back to 1
        cfg_mult = 3'd0;
        hs_pulse(1'b1);
        check_eq("fs4_lines0", lines_out, 0);
        check_eq("m0_stable", h_unstable, 0);
        run_to(250); check_eq("m0_sub", sub_now(), 0);
                     check_eq("m0_h50", hcnt_now(), 50);
        run_to(299);
        cfg_mult = 3'd6;
        hs_pulse(1'b1);
        check_eq("m6_stable", h_unstable, 0);
        run_to(150); check_eq("m6_sub", sub_now(), 0);
        run_to(199);

        // Early line start at sub-line 2
        cfg_mult = 3'd5;
        hs_pulse(1'b1);
        check_eq("m5_stable", h_unstable, 0);
        run_to(250); check_eq("early_sub2", sub_now(), 2);
                     check_eq("early_pre", h_unstable, 0);
        hs_pulse(1'b0);
        check_eq("early_warn", h_unstable, 1);
        check_eq("early_sub0", sub_now(), 0);
        check_eq("early_h0", hcnt_now(), 0);
        run_to(62);  check_eq("warn_hold", h_unstable, 1);
        run_to(63);  check_eq("warn_wrap", h_unstable, 0);

        // Line start on the last sub-line but mid-line
        run_to(450); check_eq("mid_sub4", sub_now(), 4);
                     check_eq("mid_h50", hcnt_now(), 50);
        hs_pulse(1'b0);
        check_eq("mid_warn", h_unstable, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
